// File: rtl/exe_pipe_ctrl_pkg.sv
// Shared types and constants for the EXE-stage pipeline controller.
package exe_pipe_ctrl_pkg;

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned ALU_CMD_W = 4;
   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned NZCV_W    = 4;

   // Bit positions of the condition flags inside an NZCV nibble
   localparam int unsigned NZCV_N = 3;
   localparam int unsigned NZCV_Z = 2;
   localparam int unsigned NZCV_C = 1;
   localparam int unsigned NZCV_V = 0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_HOLD   = 2'd2
   } pipe_state_e;

   // Payload carried by the ID/EXE pipeline register
   typedef struct packed {
      logic                 valid;
      logic                 wb_en;
      logic                 mem_read;
      logic                 mem_write;
      logic                 b;
      logic                 s;
      logic                 i;
      logic [ALU_CMD_W-1:0] alu_cmd;
      logic [REG_IDX_W-1:0] dest;
   } exe_ctrl_t;

   localparam exe_ctrl_t EXE_BUBBLE = '0;

   // Saturating increment for the performance counters
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/exe_pipe_ctrl_hazard_unit.sv
// Load-use hazard detection between the ID instruction and a load in EXE.
module hazard_unit
   import exe_pipe_ctrl_pkg::*;
(
   input  logic                 i_id_valid,
   input  logic [REG_IDX_W-1:0] i_id_src1,
   input  logic [REG_IDX_W-1:0] i_id_src2,
   input  logic                 i_id_two_src,
   input  logic                 i_exe_valid,
   input  logic                 i_exe_mem_read,
   input  logic [REG_IDX_W-1:0] i_exe_dest,
   output logic                 o_hazard_c
);

   logic w_src1_match;
   logic w_src2_match;

   // src2 only matters when the instruction actually reads it
   always_comb begin
      w_src1_match = (i_id_src1 == i_exe_dest);
      w_src2_match = i_id_two_src & (i_id_src2 == i_exe_dest);
      o_hazard_c   = i_id_valid & i_exe_valid & i_exe_mem_read &
                     (w_src1_match | w_src2_match);
   end

endmodule

// File: rtl/exe_pipe_ctrl.sv
// ID/EXE pipeline register with stall/flush control, NZCV status register,
// debug FSM and saturating stall/flush performance counters.
module exe_pipe_ctrl
   import exe_pipe_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 freeze,
   input  logic                 id_valid,
   input  logic                 id_wb_en,
   input  logic                 id_mem_read,
   input  logic                 id_mem_write,
   input  logic                 id_b,
   input  logic                 id_s,
   input  logic                 id_i,
   input  logic [ALU_CMD_W-1:0] id_alu_cmd,
   input  logic [REG_IDX_W-1:0] id_dest,
   input  logic [REG_IDX_W-1:0] id_src1,
   input  logic [REG_IDX_W-1:0] id_src2,
   input  logic                 id_two_src,
   input  logic [NZCV_W-1:0]    alu_status,
   output logic                 exe_valid,
   output logic                 exe_wb_en,
   output logic                 exe_mem_read,
   output logic                 exe_mem_write,
   output logic                 exe_b,
   output logic                 exe_s,
   output logic                 exe_i,
   output logic [ALU_CMD_W-1:0] exe_alu_cmd,
   output logic [REG_IDX_W-1:0] exe_dest,
   output logic [NZCV_W-1:0]    status_reg,
   output logic                 stall,
   output logic                 flush,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt,
   output logic [1:0]           state
);

   exe_ctrl_t        r_exe;
   exe_ctrl_t        w_id_ctrl;
   logic [NZCV_W-1:0] r_status;
   pipe_state_e      r_state;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_hazard;
   logic             w_flush;
   logic             w_stall;
   logic             w_bubble;
   logic             w_status_upd;

   hazard_unit u_hazard (
      .i_id_valid     (id_valid),
      .i_id_src1      (id_src1),
      .i_id_src2      (id_src2),
      .i_id_two_src   (id_two_src),
      .i_exe_valid    (r_exe.valid),
      .i_exe_mem_read (r_exe.mem_read),
      .i_exe_dest     (r_exe.dest),
      .o_hazard_c     (w_hazard)
   );

   // Pipeline control: a taken branch beats a load-use stall; freeze masks both
   always_comb begin
      w_flush      = r_exe.valid & r_exe.b & ~freeze;
      w_stall      = w_hazard & ~w_flush & ~freeze;
      w_bubble     = w_flush | w_stall;
      w_status_upd = ~freeze & r_exe.valid & r_exe.s;
   end

   // Qualify ID control bits so an invalid slot never carries side effects
   always_comb begin
      w_id_ctrl           = EXE_BUBBLE;
      w_id_ctrl.valid     = id_valid;
      w_id_ctrl.wb_en     = id_wb_en     & id_valid;
      w_id_ctrl.mem_read  = id_mem_read  & id_valid;
      w_id_ctrl.mem_write = id_mem_write & id_valid;
      w_id_ctrl.b         = id_b         & id_valid;
      w_id_ctrl.s         = id_s         & id_valid;
      w_id_ctrl.i         = id_i         & id_valid;
      w_id_ctrl.alu_cmd   = id_alu_cmd;
      w_id_ctrl.dest      = id_dest;
   end

   // ID/EXE register: freeze holds, flush/stall insert a bubble, else load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exe <= EXE_BUBBLE;
      end else if (!freeze) begin
         if (w_bubble) begin
            r_exe <= EXE_BUBBLE;
         end else begin
            r_exe <= w_id_ctrl;
         end
      end
   end

   // Architectural NZCV, captured from the ALU of an S-flagged EXE instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status <= '0;
      end else if (w_status_upd) begin
         r_status[NZCV_N] <= alu_status[NZCV_N];
         r_status[NZCV_Z] <= alu_status[NZCV_Z];
         r_status[NZCV_C] <= alu_status[NZCV_C];
         r_status[NZCV_V] <= alu_status[NZCV_V];
      end
   end

   // Debug FSM tracking what the pipeline register did on the last edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else if (freeze) begin
         r_state <= ST_HOLD;
      end else if (w_bubble) begin
         r_state <= ST_BUBBLE;
      end else begin
         r_state <= ST_RUN;
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
         end
         if (w_flush) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
         end
      end
   end

   assign exe_valid     = r_exe.valid;
   assign exe_wb_en     = r_exe.wb_en;
   assign exe_mem_read  = r_exe.mem_read;
   assign exe_mem_write = r_exe.mem_write;
   assign exe_b         = r_exe.b;
   assign exe_s         = r_exe.s;
   assign exe_i         = r_exe.i;
   assign exe_alu_cmd   = r_exe.alu_cmd;
   assign exe_dest      = r_exe.dest;
   assign status_reg    = r_status;
   assign stall         = w_stall;
   assign flush         = w_flush;
   assign stall_cnt     = r_stall_cnt;
   assign flush_cnt     = r_flush_cnt;
   assign state         = r_state;

endmodule
